// File: rtl/rst_sequencer_if.sv
// ----------------------------------------------------------------------------
// rst_sequencer_if
// Control/status bundle between the reset sequencer and its controller.
//   soft_rst_req : request a full reset re-sequence
//   wdt_kick     : progress indication, clears the watchdog
//   rst_out      : per-channel active-high reset to downstream blocks
//   ready        : all channels released, sequencer in RUN
//   wdt_fired    : one-cycle pulse on watchdog-forced re-sequence
//   reset_cause  : 00 external rst, 01 soft, 10 watchdog
//   reset_cnt    : saturating count of soft + watchdog re-sequences
// master = requesting side (SoC / bench), slave = the sequencer.
// ----------------------------------------------------------------------------
interface rst_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              soft_rst_req;
    logic              wdt_kick;
    logic [NUM_CH-1:0] rst_out;
    logic              ready;
    logic              wdt_fired;
    logic [1:0]        reset_cause;
    logic [7:0]        reset_cnt;

    modport master (
        output soft_rst_req, wdt_kick,
        input  rst_out, ready, wdt_fired, reset_cause, reset_cnt
    );

    modport slave (
        input  soft_rst_req, wdt_kick,
        output rst_out, ready, wdt_fired, reset_cause, reset_cnt
    );
endinterface

// File: rtl/rst_sequencer.sv
// ----------------------------------------------------------------------------
// rst_sequencer
// Staggered per-channel reset release with soft-reset request and a liveness
// watchdog. After the reset cause clears, all channels stay asserted for
// HOLD_CYCLES edges, then channel i releases STAGGER*i edges after channel 0.
// In RUN the watchdog (if WDT_CYCLES != 0) re-sequences the system when no
// wdt_kick arrives for WDT_CYCLES edges.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : rst_sequencer_if.slave (requests in, channel resets and status out)
// All outputs are registered; no combinational input-to-output path.
// ----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 25,
    parameter int STAGGER     = 4,
    parameter int WDT_CYCLES  = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    rst_sequencer_if.slave      bus
);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;

    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_REL  = CNT_W'(HOLD_CYCLES + (NUM_CH - 1) * STAGGER);
    localparam logic [CNT_W-1:0] WDT_LIMIT = CNT_W'(WDT_CYCLES);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  wdt;
    logic [NUM_CH-1:0] rst_out_q;
    logic              ready_q;
    logic              wdt_fired_q;
    logic [1:0]        reset_cause_q;
    logic [7:0]        reset_cnt_q;

    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  wdt_inc;
    logic [NUM_CH-1:0] clr_mask;
    logic              wdt_expire;

    // Release schedule: channel i clears on the edge cnt becomes
    // HOLD_CYCLES + i*STAGGER. With STAGGER = 0 every channel matches at once.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_inc  = cnt + 1'b1;
        wdt_inc  = wdt + 1'b1;
        clr_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_inc == CNT_W'(HOLD_CYCLES + i * STAGGER))
                clr_mask[i] = 1'b1;
        end
        // A kick on the would-be expiry edge suppresses the expiry.
        wdt_expire = (WDT_CYCLES != 0) && (state == ST_RUN) &&
                     !bus.wdt_kick && (wdt_inc == WDT_LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_HOLD;
            cnt           <= '0;
            wdt           <= '0;
            rst_out_q     <= '1;
            ready_q       <= 1'b0;
            wdt_fired_q   <= 1'b0;
            reset_cause_q <= CAUSE_EXT;
            reset_cnt_q   <= '0;
        end else if (wdt_expire || bus.soft_rst_req) begin
            // Full re-sequence; watchdog outranks a simultaneous soft request
            // and the event is counted once.
            state         <= ST_HOLD;
            cnt           <= '0;
            wdt           <= '0;
            rst_out_q     <= '1;
            ready_q       <= 1'b0;
            wdt_fired_q   <= wdt_expire;
            reset_cause_q <= wdt_expire ? CAUSE_WDT : CAUSE_SOFT;
            if (reset_cnt_q != 8'hFF)
                reset_cnt_q <= reset_cnt_q + 8'd1;
        end else begin
            wdt_fired_q <= 1'b0;
            case (state)
                ST_HOLD: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == HOLD_END) begin
                        rst_out_q <= rst_out_q & ~clr_mask;
                        if (cnt_inc == LAST_REL) begin
                            // Single channel or zero stagger: straight to RUN.
                            state   <= ST_RUN;
                            ready_q <= 1'b1;
                            wdt     <= '0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    cnt       <= cnt_inc;
                    rst_out_q <= rst_out_q & ~clr_mask;
                    if (cnt_inc == LAST_REL) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        wdt     <= '0;
                    end
                end
                ST_RUN: begin
                    if (WDT_CYCLES != 0)
                        wdt <= bus.wdt_kick ? '0 : wdt_inc;
                end
                default: begin
                    state <= ST_HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.rst_out     = rst_out_q;
    assign bus.ready       = ready_q;
    assign bus.wdt_fired   = wdt_fired_q;
    assign bus.reset_cause = reset_cause_q;
    assign bus.reset_cnt   = reset_cnt_q;

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer and liveness watchdog placed between the board/bench reset source (`btnC` on hardware, the bench-driven `rst` in simulation) and the reset inputs of `riscv_top` sub-blocks (CPU core, memory controller, HCI/UART). It replaces the fixed single-reset hold with a per-channel staggered release, a software-requested reset and a watchdog that re-sequences the system when no progress is reported. One clock domain; all outputs are registered.

## Interface
Parameters:
- `NUM_CH`, 3: number of reset channels, >= 1; channel 0 is released first.
- `HOLD_CYCLES`, 25: edges all channels stay asserted after reset cause clears, >= 1.
- `STAGGER`, 4: edges between release of channel i and channel i+1; 0 releases all together.
- `WDT_CYCLES`, 0: watchdog timeout in edges while in RUN; 0 disables the watchdog.
- `CNT_W`, 16: counter width; must hold `HOLD_CYCLES + (NUM_CH-1)*STAGGER` and `WDT_CYCLES`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `soft_rst_req` in 1: request full re-sequence; sampled on each edge.
- `wdt_kick` in 1: progress indication; clears watchdog counter.
- `rst_out` out `NUM_CH`: per-channel active-high synchronous reset to downstream blocks.
- `ready` out 1: all channels released, sequencer in RUN.
- `wdt_fired` out 1: one-cycle pulse when watchdog expiry forces re-sequence.
- `reset_cause` out 2: cause of last sequence: 00 external `rst`, 01 soft, 10 watchdog.
- `reset_cnt` out 8: saturating count of soft+watchdog re-sequences since `rst`.

## Operation
- States: HOLD, RELEASE, RUN. Single counter `cnt` (CNT_W bits) shared; watchdog counter `wdt` separate.
- `rst` high at an edge: state HOLD, `cnt`=0, `wdt`=0, `rst_out`=all ones, `ready`=0, `wdt_fired`=0, `reset_cause`=00, `reset_cnt`=0. These are the reset values of every output.
- HOLD: `cnt` increments each edge; when incremented value equals `HOLD_CYCLES`, clear channel 0 and go RELEASE (or RUN directly if `NUM_CH`=1 or `STAGGER`=0, clearing all channels and setting `ready`).
- RELEASE: `cnt` keeps counting; channel i cleared on the edge `cnt` becomes `HOLD_CYCLES + i*STAGGER`; on the edge the last channel clears, `ready`=1, state RUN, `wdt`=0.
- RUN: if `WDT_CYCLES`!=0, `wdt` increments each edge without `wdt_kick`, clears on edges with it. Increment reaching `WDT_CYCLES` = expiry.
- Re-sequence (soft or watchdog): state HOLD, `cnt`=0, `rst_out`=all ones, `ready`=0, `reset_cause` updated, `reset_cnt` incremented (saturates at 255); `wdt_fired`=1 for that one cycle on watchdog cause only.
- Priority per edge: `rst` > watchdog expiry > `soft_rst_req` > normal counting.
- `wdt_kick` in the same edge expiry would occur: kick wins, no expiry.
- `soft_rst_req` in HOLD or RELEASE: restarts sequence (cnt=0, all channels reasserted), counts in `reset_cnt`, cause 01.
- `wdt_kick` outside RUN: ignored. Watchdog never counts outside RUN.
- Channels, once cleared, stay cleared until next re-sequence; never reassert individually.

## Timing
- First edge with `rst`=0 is count edge 1; `rst_out[i]` falls after edge `HOLD_CYCLES + i*STAGGER` (relative to that edge as 1); `ready` rises on the same edge as `rst_out[NUM_CH-1]` falls.
- `soft_rst_req` sampled at edge k: `rst_out` all ones and `ready`=0 visible after edge k (1-cycle latency); next release at edge k+`HOLD_CYCLES`.
- Watchdog: with no kicks after entering RUN at edge r, expiry at edge r+`WDT_CYCLES`; `wdt_fired` high for exactly the following cycle.
- No combinational path from any input to any output.

## Test plan
- Defaults (3 ch, 25, 4, WDT 0): hold `rst` 25 edges, drop -> `rst_out` 111 until edge 25, 110 after 25, 100 after 29, 000 and `ready`=1 after 33; `reset_cause`=00.
- `STAGGER`=0: `rst_out` goes 111->000 in one edge at edge 25, `ready` same edge; `NUM_CH`=1 behaves identically.
- Soft reset in RUN at edge 50: after edge 50 `rst_out`=111, `ready`=0, cause=01, `reset_cnt`=1; channel 0 releases after edge 75; soft request again during RELEASE restarts hold count, `reset_cnt`=2.
- `WDT_CYCLES`=100, kick every 60 edges for 1000 edges -> no expiry; stop kicks -> `wdt_fired` pulse exactly one cycle 100 edges after last kick, cause=10, full re-sequence follows.
- Simultaneous kick and expiry edge -> no expiry; simultaneous `soft_rst_req` and expiry -> cause=10, `wdt_fired`=1, `reset_cnt`+1 only once.
- `rst` mid-RELEASE and 300 re-sequences: `rst` returns all outputs to reset values immediately after edge; `reset_cnt` saturates at 255.
